// File: rtl/fighter_anim_pkg.sv
// Shared types and defaults for the fighter animation controller:
// sprite encodings, FSM states, pending-request bundle and pose thresholds.
package fighter_anim_pkg;

    typedef enum logic [2:0] {
        SPR_STAND   = 3'd0,
        SPR_RAGE    = 3'd1,
        SPR_BREATHE = 3'd2,
        SPR_WALK    = 3'd3,
        SPR_PUNCH   = 3'd4,
        SPR_KICK    = 3'd5,
        SPR_HIT     = 3'd6
    } sprite_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WALK  = 3'd1,
        ST_PUNCH = 3'd2,
        ST_KICK  = 3'd3,
        ST_HIT   = 3'd4
    } state_e;

    typedef struct packed {
        logic punch;
        logic kick;
        logic hit;
    } pend_t;

    localparam int DEF_RAGE_THRESH  = 120;
    localparam int DEF_IDLE_PERIOD  = 25;
    localparam int DEF_WALK_PERIOD  = 25;
    localparam int DEF_PUNCH_FRAMES = 8;
    localparam int DEF_KICK_FRAMES  = 10;
    localparam int DEF_HIT_FRAMES   = 6;

    // Frame-count windows that pick the secondary pose in IDLE and WALK.
    localparam logic [5:0] BREATHE_FIRST   = 6'd13;
    localparam logic [5:0] WALK_POSE_FIRST = 6'd3;
    localparam logic [5:0] WALK_POSE_LAST  = 6'd11;

    function automatic logic is_action(state_e st);
        return (st == ST_PUNCH) || (st == ST_KICK) || (st == ST_HIT);
    endfunction

endpackage

// File: rtl/fighter_anim_ctrl_if.sv
// Bundle of frame sync, fighter inputs, request pulses and animation outputs.
// The master side drives the inputs and observes the sprite selection.
interface fighter_anim_ctrl_if;

    logic       vsync;
    logic [9:0] motionx;
    logic [7:0] health;
    logic       punch_req;
    logic       kick_req;
    logic       hit_req;
    logic [2:0] sprite_sel;
    logic [5:0] frame_cnt;
    logic       anim_busy;
    logic       action_done;

    modport master (
        output vsync, motionx, health, punch_req, kick_req, hit_req,
        input  sprite_sel, frame_cnt, anim_busy, action_done
    );

    modport slave (
        input  vsync, motionx, health, punch_req, kick_req, hit_req,
        output sprite_sel, frame_cnt, anim_busy, action_done
    );

endinterface

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on vsync; emits a one-cycle frame_tick per frame.
module frame_tick_gen (
    input  logic vga_clk,
    input  logic reset_n,
    input  logic vsync,
    output logic frame_tick
);

    logic vsync_q;

    // NOTE: sequential state uses non-blocking assignments; reset is sampled on the clock edge.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            vsync_q <= 1'b1;   // a vsync already high at release is not a new frame
        end else begin
            vsync_q <= vsync;
        end
    end

    assign frame_tick = vsync & ~vsync_q;

endmodule

// File: rtl/fighter_anim_ctrl.sv
// Per-frame sprite sequencer for one fighter: idle/walk loops, queued
// punch/kick/hit actions with hit preemption, and a completion pulse.
module fighter_anim_ctrl
    import fighter_anim_pkg::*;
#(
    parameter int RAGE_THRESH  = DEF_RAGE_THRESH,
    parameter int IDLE_PERIOD  = DEF_IDLE_PERIOD,
    parameter int WALK_PERIOD  = DEF_WALK_PERIOD,
    parameter int PUNCH_FRAMES = DEF_PUNCH_FRAMES,
    parameter int KICK_FRAMES  = DEF_KICK_FRAMES,
    parameter int HIT_FRAMES   = DEF_HIT_FRAMES
) (
    input logic                vga_clk,
    input logic                reset_n,
    fighter_anim_ctrl_if.slave anim
);

    localparam logic [7:0] RAGE_LVL   = 8'(RAGE_THRESH);
    localparam logic [5:0] IDLE_LAST  = 6'(IDLE_PERIOD - 1);
    localparam logic [5:0] WALK_LAST  = 6'(WALK_PERIOD - 1);
    localparam logic [5:0] PUNCH_LAST = 6'(PUNCH_FRAMES - 1);
    localparam logic [5:0] KICK_LAST  = 6'(KICK_FRAMES - 1);
    localparam logic [5:0] HIT_LAST   = 6'(HIT_FRAMES - 1);

    logic       frame_tick;
    state_e     state_q, state_d;
    logic [5:0] cnt_q, cnt_d;
    sprite_e    sprite_q, sprite_d;
    pend_t      pend_q, pend_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;

    logic       moving;
    state_e     rest_state;
    sprite_e    base_pose;
    logic       enter_punch, enter_kick, enter_hit;

    frame_tick_gen u_frame_tick (
        .vga_clk   (vga_clk),
        .reset_n   (reset_n),
        .vsync     (anim.vsync),
        .frame_tick(frame_tick)
    );

    function automatic sprite_e pose_for(state_e st, logic [5:0] cnt, sprite_e base);
        case (st)
            ST_IDLE:  return (cnt < BREATHE_FIRST) ? base : SPR_BREATHE;
            ST_WALK:  return (cnt >= WALK_POSE_FIRST && cnt <= WALK_POSE_LAST) ? SPR_WALK : base;
            ST_PUNCH: return SPR_PUNCH;
            ST_KICK:  return SPR_KICK;
            default:  return SPR_HIT;
        endcase
    endfunction

    assign moving     = (anim.motionx != 10'd0);
    assign rest_state = moving ? ST_WALK : ST_IDLE;
    assign base_pose  = (anim.health >= RAGE_LVL) ? SPR_RAGE : SPR_STAND;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        if (frame_tick) begin
            case (state_q)
                ST_IDLE, ST_WALK: begin
                    if (pend_q.hit) begin
                        state_d = ST_HIT;
                        cnt_d   = '0;
                    end else if (pend_q.kick) begin
                        state_d = ST_KICK;
                        cnt_d   = '0;
                    end else if (pend_q.punch) begin
                        state_d = ST_PUNCH;
                        cnt_d   = '0;
                    end else if (rest_state != state_q) begin
                        state_d = rest_state;
                        cnt_d   = '0;
                    end else if (state_q == ST_IDLE) begin
                        cnt_d = (cnt_q == IDLE_LAST) ? 6'd0 : cnt_q + 6'd1;
                    end else begin
                        cnt_d = (cnt_q == WALK_LAST) ? 6'd0 : cnt_q + 6'd1;
                    end
                end
                ST_PUNCH, ST_KICK: begin
                    if (pend_q.hit) begin
                        state_d = ST_HIT;          // preemption: no completion pulse
                        cnt_d   = '0;
                    end else if (cnt_q == ((state_q == ST_PUNCH) ? PUNCH_LAST : KICK_LAST)) begin
                        state_d = rest_state;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                ST_HIT: begin
                    if (cnt_q == HIT_LAST) begin
                        state_d = rest_state;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_comb begin
        sprite_d = sprite_q;
        if (frame_tick) begin
            sprite_d = pose_for(state_d, cnt_d, base_pose);
        end
    end

    // Actions are only ever entered from a different state, so a state change marks entry.
    assign enter_punch = (state_d == ST_PUNCH) && (state_q != ST_PUNCH);
    assign enter_kick  = (state_d == ST_KICK)  && (state_q != ST_KICK);
    assign enter_hit   = (state_d == ST_HIT)   && (state_q != ST_HIT);

    always_comb begin
        pend_d.punch = anim.punch_req | (pend_q.punch & ~(enter_punch | enter_hit));
        pend_d.kick  = anim.kick_req  | (pend_q.kick  & ~(enter_kick  | enter_hit));
        pend_d.hit   = anim.hit_req   | (pend_q.hit   & ~enter_hit);
    end

    assign busy_d = is_action(state_d);

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            sprite_q <= SPR_STAND;
            pend_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sprite_q <= sprite_d;
            pend_q   <= pend_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign anim.sprite_sel  = sprite_q;
    assign anim.frame_cnt   = cnt_q;
    assign anim.anim_busy   = busy_q;
    assign anim.action_done = done_q;

endmodule

// File: tb/tb_fighter_anim_ctrl.sv
// Self-checking bench: directed scenarios plus randomized frames, each cycle
// compared against a behavioural model of the animation rules.
module tb_fighter_anim_ctrl;

    localparam int RAGE    = 120;
    localparam int IDLE_P  = 25;
    localparam int WALK_P  = 25;
    localparam int PUNCH_N = 8;
    localparam int KICK_N  = 10;
    localparam int HIT_N   = 6;

    // Model activity numbering, private to the bench.
    localparam int M_IDLE  = 0;
    localparam int M_WALK  = 1;
    localparam int M_PUNCH = 2;
    localparam int M_KICK  = 3;
    localparam int M_HIT   = 4;

    logic vga_clk = 1'b0;
    logic reset_n = 1'b0;

    fighter_anim_ctrl_if anim_if ();

    fighter_anim_ctrl dut (
        .vga_clk(vga_clk),
        .reset_n(reset_n),
        .anim   (anim_if)
    );

    always #5 vga_clk = ~vga_clk;

    int checks    = 0;
    int failures  = 0;
    int done_seen = 0;

    int dur [5] = '{IDLE_P, WALK_P, PUNCH_N, KICK_N, HIT_N};

    int m_mode;
    int m_cnt;
    int m_sprite;
    bit m_busy, m_done;
    bit m_pp, m_kp, m_hp;
    bit m_vs_prev;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int pose(input int mode, input int cnt, input int hl);
        int base;
        base = (hl >= RAGE) ? 1 : 0;
        case (mode)
            M_IDLE:  return (cnt <= 12) ? base : 2;
            M_WALK:  return (cnt >= 3 && cnt <= 11) ? 3 : base;
            M_PUNCH: return 4;
            M_KICK:  return 5;
            default: return 6;
        endcase
    endfunction

    task automatic model_step(input bit rst, input bit vs, input int mx, input int hl,
                              input bit pr, input bit kr, input bit hr);
        bit tick, fp, fk, fh, moving;
        int nxt;
        if (!rst) begin
            m_mode = M_IDLE; m_cnt = 0; m_sprite = 0;
            m_busy = 0; m_done = 0;
            m_pp = 0; m_kp = 0; m_hp = 0;
            m_vs_prev = 1;
            return;
        end
        tick = vs && !m_vs_prev;
        m_vs_prev = vs;
        fp = m_pp; fk = m_kp; fh = m_hp;
        m_done = 0;
        if (tick) begin
            moving = (mx != 0);
            nxt = -1;
            if (m_mode <= M_WALK) begin
                if (fh)      nxt = M_HIT;
                else if (fk) nxt = M_KICK;
                else if (fp) nxt = M_PUNCH;
                else if ((m_mode == M_WALK) != moving) begin
                    m_mode = moving ? M_WALK : M_IDLE;
                    m_cnt = 0;
                end else begin
                    m_cnt = (m_cnt + 1) % dur[m_mode];
                end
            end else if (m_mode != M_HIT && fh) begin
                nxt = M_HIT;
            end else if (m_cnt == dur[m_mode] - 1) begin
                m_mode = moving ? M_WALK : M_IDLE;
                m_cnt = 0;
                m_done = 1;
            end else begin
                m_cnt++;
            end
            if (nxt >= 0) begin
                m_mode = nxt;
                m_cnt = 0;
                if (nxt == M_HIT) begin fp = 0; fk = 0; fh = 0; end
                if (nxt == M_KICK) fk = 0;
                if (nxt == M_PUNCH) fp = 0;
            end
            m_sprite = pose(m_mode, m_cnt, hl);
        end
        m_pp = fp | pr;
        m_kp = fk | kr;
        m_hp = fh | hr;
        m_busy = (m_mode >= M_PUNCH);
    endtask

    task automatic cycle();
        bit r, v, p, k, h;
        int mx, hl;
        r = reset_n; v = anim_if.vsync;
        mx = int'(anim_if.motionx); hl = int'(anim_if.health);
        p = anim_if.punch_req; k = anim_if.kick_req; h = anim_if.hit_req;
        @(posedge vga_clk);
        model_step(r, v, mx, hl, p, k, h);
        #1;
        check("sprite_sel", int'(anim_if.sprite_sel), m_sprite);
        check("frame_cnt", int'(anim_if.frame_cnt), m_cnt);
        check("anim_busy", int'(anim_if.anim_busy), int'(m_busy));
        check("action_done", int'(anim_if.action_done), int'(m_done));
        if (anim_if.action_done) done_seen++;
    endtask

    // One frame: low phase (requests pulsed in its first cycle), then high phase.
    task automatic frame(input bit p = 0, input bit k = 0, input bit h = 0,
                         input int lo = 2, input int hi = 2);
        anim_if.vsync = 1'b0;
        anim_if.punch_req = p; anim_if.kick_req = k; anim_if.hit_req = h;
        cycle();
        anim_if.punch_req = 0; anim_if.kick_req = 0; anim_if.hit_req = 0;
        for (int i = 1; i < lo; i++) cycle();
        anim_if.vsync = 1'b1;
        for (int i = 0; i < hi; i++) cycle();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cycle();
        cycle();
        reset_n = 1'b1;
    endtask

    task automatic frames_until(input string tag, input int mode, input int cnt);
        int n;
        n = 0;
        while (!(m_mode == mode && m_cnt == cnt) && n < 40) begin
            frame();
            n++;
        end
        check(tag, int'(m_mode == mode && m_cnt == cnt), 1);
    endtask

    initial begin
        int e;
        anim_if.vsync = 0; anim_if.motionx = '0; anim_if.health = 8'd100;
        anim_if.punch_req = 0; anim_if.kick_req = 0; anim_if.hit_req = 0;

        // Reset state
        reset_n = 1'b0;
        cycle();
        cycle();
        check("rst_sprite", int'(anim_if.sprite_sel), 0);
        check("rst_cnt", int'(anim_if.frame_cnt), 0);
        check("rst_busy", int'(anim_if.anim_busy), 0);
        check("rst_done", int'(anim_if.action_done), 0);
        reset_n = 1'b1;

        // Idle breathe cycle, health below rage threshold
        for (int i = 1; i <= 30; i++) begin
            frame();
            e = i % 25;
            check("idle_cnt", int'(anim_if.frame_cnt), e);
            check("idle_pose", int'(anim_if.sprite_sel), (e <= 12) ? 0 : 2);
        end

        // Walk cycle in rage, then stop
        anim_if.health = 8'd130;
        anim_if.motionx = 10'd2;
        frame();
        check("walk_enter_cnt", int'(anim_if.frame_cnt), 0);
        check("walk_enter_pose", int'(anim_if.sprite_sel), 1);
        for (int j = 1; j <= 25; j++) begin
            frame();
            e = j % 25;
            check("walk_cnt", int'(anim_if.frame_cnt), e);
            check("walk_pose", int'(anim_if.sprite_sel), (e >= 3 && e <= 11) ? 3 : 1);
        end
        anim_if.motionx = '0;
        frame();
        check("stop_cnt", int'(anim_if.frame_cnt), 0);
        check("stop_pose", int'(anim_if.sprite_sel), 1);

        // Simultaneous punch and kick: kick first, then punch
        anim_if.health = 8'd100;
        done_seen = 0;
        frame(1, 1, 0);
        check("pk_kick_first", int'(anim_if.sprite_sel), 5);
        for (int t = 2; t <= 25; t++) begin
            frame();
            if (t == 10) check("pk_kick_last", int'(anim_if.frame_cnt), 9);
            if (t == 11) check("pk_done_after_kick", done_seen, 1);
            if (t == 12) check("pk_punch_next", int'(anim_if.sprite_sel), 4);
        end
        check("pk_done_total", done_seen, 2);
        check("pk_idle_busy", int'(anim_if.anim_busy), 0);
        check("pk_idle_cnt", int'(anim_if.frame_cnt), 5);

        // Hit preempts punch at count 4
        done_seen = 0;
        frame(1, 0, 0);
        frames_until("wait_punch4", M_PUNCH, 4);
        check("ph_punch_cnt", int'(anim_if.frame_cnt), 4);
        frame(0, 0, 1);
        check("ph_hit_pose", int'(anim_if.sprite_sel), 6);
        check("ph_hit_cnt", int'(anim_if.frame_cnt), 0);
        for (int t = 0; t < 5; t++) frame();
        check("ph_no_done", done_seen, 0);
        frame();
        check("ph_done", done_seen, 1);
        check("ph_exit_busy", int'(anim_if.anim_busy), 0);

        // vsync held high across reset release: no tick until a fresh rise
        anim_if.vsync = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) cycle();
        check("vs_hold_cnt", int'(anim_if.frame_cnt), 0);
        anim_if.vsync = 1'b0;
        cycle();
        cycle();
        anim_if.vsync = 1'b1;
        cycle();
        cycle();
        check("vs_rise_cnt", int'(anim_if.frame_cnt), 1);

        // Reset in the middle of a kick
        done_seen = 0;
        frame(0, 1, 0);
        frames_until("wait_kick5", M_KICK, 5);
        anim_if.vsync = 1'b0;
        reset_n = 1'b0;
        cycle();
        check("mr_sprite", int'(anim_if.sprite_sel), 0);
        check("mr_cnt", int'(anim_if.frame_cnt), 0);
        check("mr_busy", int'(anim_if.anim_busy), 0);
        check("mr_done", int'(anim_if.action_done), 0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) frame();
        check("mr_no_done", done_seen, 0);

        // Randomized frames
        for (int f = 0; f < 250; f++) begin
            if ($urandom_range(0, 49) == 0) do_reset();
            anim_if.motionx = ($urandom_range(0, 1) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
            anim_if.health  = 8'($urandom_range(0, 255));
            frame(($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 7) == 0),
                  int'($urandom_range(1, 3)), int'($urandom_range(1, 3)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fighter_anim_ctrl.md
FIGHTER_ANIM_CTRL -- requirements
Module: fighter_anim_ctrl

Interface
REQ-001 SHALL have parameter RAGE_THRESH, default 120: health at or above this selects the rage base pose.
REQ-002 SHALL have parameter IDLE_PERIOD, default 25: idle breathe cycle length, in frames.
REQ-003 SHALL have parameter WALK_PERIOD, default 25: walk cycle length, in frames.
REQ-004 SHALL have parameters PUNCH_FRAMES = 8, KICK_FRAMES = 10 and HIT_FRAMES = 6: action durations, in frames.
REQ-005 SHALL have port vga_clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset_n, input, 1 bit: reset, synchronous and active-low.
REQ-007 SHALL have port vsync, input, 1 bit: frame sync, level, synchronous to vga_clk.
REQ-008 SHALL have port motionx, input, 10 bits: horizontal motion; nonzero means walking.
REQ-009 SHALL have port health, input, 8 bits: fighter health value.
REQ-010 SHALL have ports punch_req, kick_req and hit_req, input, 1 bit each: single-cycle request pulses.
REQ-011 SHALL have port sprite_sel, output, 3 bits: STAND=0, RAGE=1, BREATHE=2, WALK=3, PUNCH=4, KICK=5, HIT=6.
REQ-012 SHALL have port frame_cnt, output, 6 bits: frame index within the current state.
REQ-013 SHALL have port anim_busy, output, 1 bit: high while the state is PUNCH, KICK or HIT.
REQ-014 SHALL have port action_done, output, 1 bit: one-cycle pulse when an action completes.

Function
REQ-015 SHALL register vsync into vsync_q; frame_tick = vsync & ~vsync_q, a one-cycle pulse.
REQ-016 SHALL change state, frame_cnt and sprite_sel only on the vga_clk edge that ends a frame_tick cycle; all outputs are registered.
REQ-017 SHALL keep pending flags punch_p, kick_p and hit_p:
- each is set by its req in any cycle;
- each is cleared on entry to its state;
- entering HIT clears all three;
- if set and clear coincide, set wins.
REQ-018 SHALL implement FSM states IDLE, WALK, PUNCH, KICK and HIT.
REQ-019 SHALL apply this priority at each tick in IDLE or WALK: hit_p > kick_p > punch_p > motion.
REQ-020 SHALL move IDLE to WALK at a tick when motionx != 0, and WALK to IDLE when motionx == 0; each change sets frame_cnt = 0.
REQ-021 SHALL, in IDLE, count frame_cnt 0..IDLE_PERIOD-1 and wrap to 0; it SHALL output the base pose for counts 0..12 and BREATHE for 13..IDLE_PERIOD-1.
REQ-022 SHALL, in WALK, count 0..WALK_PERIOD-1 and wrap to 0; it SHALL output WALK for counts 3..11 and the base pose otherwise (count 2 gives base).
REQ-023 SHALL select the base pose as RAGE when health >= RAGE_THRESH, else STAND; health is sampled at the tick.
REQ-024 SHALL hold PUNCH or KICK for exactly N ticks with frame_cnt 0..N-1; at the tick with frame_cnt == N-1 it SHALL go to WALK if motionx != 0, else IDLE, with frame_cnt = 0.
REQ-025 SHALL preempt PUNCH or KICK on any tick where hit_p=1 (enter HIT, frame_cnt = 0); punch and kick never preempt each other.
REQ-026 SHALL not let HIT be preempted; a hit_req arriving during HIT sets hit_p and causes HIT to be re-entered after exit.
REQ-027 SHALL pulse action_done in the cycle after the tick that leaves PUNCH, KICK or HIT normally; preemption into HIT SHALL NOT pulse it.
REQ-028 SHALL use frame_cnt arithmetic 6 bits wide and unsigned; every parameter SHALL be in 1..63.

Reset
REQ-029 SHALL, when reset_n=0 at a clock edge:
- set state = IDLE, frame_cnt = 0 and sprite_sel = STAND;
- set anim_busy = 0 and action_done = 0;
- clear all pending flags;
- set vsync_q = 1, so there is no spurious tick after reset.
REQ-030 SHALL let reset mid-action abandon the action with no action_done.

Structure
REQ-031 SHALL put the sprite_sel encoding enum, the FSM state enum and the default constants in the shared package fighter_anim_pkg.
REQ-032 SHALL place the vsync edge detector in sub-module frame_tick_gen, ports vga_clk, reset_n, vsync and frame_tick.

Verification
REQ-033 SHALL cover idle with health=100 and motionx=0 over 30 ticks: STAND at counts 0..12, BREATHE at 13..24, wrap at tick 25.
REQ-034 SHALL cover walk with health=130 and motionx=2: RAGE at counts 0..2, WALK at 3..11, RAGE at 12..24; motionx=0 then gives IDLE with count 0.
REQ-035 SHALL cover punch_req and kick_req pulsed in the same cycle: KICK for 10 ticks, one action_done, then PUNCH for 8 ticks, then IDLE.
REQ-036 SHALL cover hit_req at PUNCH count 4: HIT at the next tick, no action_done, HIT for 6 ticks, then action_done.
REQ-037 SHALL cover vsync held high through a reset release: no tick until vsync falls and rises again.
REQ-038 SHALL cover reset_n=0 during KICK count 5: next edge gives IDLE, STAND, count 0, anim_busy=0, and no action_done.
